// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-channel FSM state encoding
// and the default debounce length (about 21 ms at 50 MHz).
package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PDEB = 2'd1,
    DOWN = 2'd2,
    RDEB = 2'd3
  } key_fsm_e;

  localparam int DEB_CYC_DEFAULT = 1048575;

endpackage

// File: rtl/key_deb_ch.sv
// Single key channel: two-flop synchronizer, four-state debounce FSM with
// a stable-level counter, and registered press/release pulses.
module key_deb_ch
  import key_pkg::*;
#(
  parameter int CNT_W   = 20,
  parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYC - 1);

  logic             sync_1;
  logic             s;
  key_fsm_e         state;
  key_fsm_e         next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             press_d;
  logic             release_d;

  // Bring the raw asynchronous key level into the clock domain; idle is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      s      <= 1'b1;
    end else begin
      sync_1 <= key_n;
      s      <= sync_1;
    end
  end

  // Debounce decisions: leave a debounce state on any bounce, accept once the
  // level has been stable long enough; the counter restarts on every entry.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    press_d    = 1'b0;
    release_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!s) begin
          next_state = PDEB;
          next_cnt   = '0;
        end
      end
      PDEB: begin
        if (s) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (cnt == LAST) begin
          next_state = DOWN;
          next_cnt   = '0;
          press_d    = 1'b1;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (s) begin
          next_state = RDEB;
          next_cnt   = '0;
        end
      end
      RDEB: begin
        if (!s) begin
          next_state = DOWN;
          next_cnt   = '0;
        end else if (cnt == LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
          release_d  = 1'b1;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // State, counter and output registers; key_state and the pulses all change
  // on the same edge as the accepting transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      key_state   <= (next_state == DOWN) || (next_state == RDEB);
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: N_KEY fully independent channels, one per key input.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEY   = 3,
  parameter int CNT_W   = 20,
  parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_KEY-1:0] key_n,
  output logic [N_KEY-1:0] key_state,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release
);

  for (genvar g = 0; g < N_KEY; g++) begin : g_ch
    key_deb_ch #(
      .CNT_W  (CNT_W),
      .DEB_CYC(DEB_CYC)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n[g]),
      .key_state  (key_state[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with a short debounce length. A run-length model
// predicts every output each cycle: a key's accepted level flips once the
// synchronized input has disagreed with it for DEB+1 consecutive edges.
module tb_key_debounce;

  localparam int N_KEY = 3;
  localparam int CNT_W = 20;
  localparam int DEB   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_KEY-1:0] key_n;
  logic [N_KEY-1:0] key_state;
  logic [N_KEY-1:0] key_press;
  logic [N_KEY-1:0] key_release;

  key_debounce #(
    .N_KEY  (N_KEY),
    .CNT_W  (CNT_W),
    .DEB_CYC(DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  int compares   = 0;
  int mismatches = 0;

  // Model: raw samples from the previous two edges, accepted level, run length
  logic [N_KEY-1:0] m1;
  logic [N_KEY-1:0] m2;
  logic [N_KEY-1:0] acc;
  logic [N_KEY-1:0] exp_press;
  logic [N_KEY-1:0] exp_release;
  int               run [N_KEY];

  // Observed-event statistics for the directed scenarios
  int cyc;
  int first_press [N_KEY];
  int first_rel   [N_KEY];
  int n_press     [N_KEY];
  int n_rel       [N_KEY];
  int n_all;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      mismatches++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m1          = '1;
    m2          = '1;
    acc         = '0;
    exp_press   = '0;
    exp_release = '0;
    for (int i = 0; i < N_KEY; i++) run[i] = 0;
  endtask

  task automatic modelStep();
    logic used;
    exp_press   = '0;
    exp_release = '0;
    for (int i = 0; i < N_KEY; i++) begin
      used  = m2[i];
      m2[i] = m1[i];
      m1[i] = key_n[i];
      if ((~used) != acc[i]) run[i]++;
      else run[i] = 0;
      if (run[i] == DEB + 1) begin
        run[i] = 0;
        acc[i] = ~acc[i];
        if (acc[i]) exp_press[i] = 1'b1;
        else exp_release[i] = 1'b1;
      end
    end
  endtask

  task automatic clearStats();
    cyc   = 0;
    n_all = 0;
    for (int i = 0; i < N_KEY; i++) begin
      first_press[i] = -1;
      first_rel[i]   = -1;
      n_press[i]     = 0;
      n_rel[i]       = 0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after the rising edge
  task automatic applyStimulus(input logic [N_KEY-1:0] kn);
    key_n = kn;
    @(posedge clk);
    modelStep();
    #1;
    cyc++;
    checkOutput("key_state", 32'(key_state), 32'(acc));
    checkOutput("key_press", 32'(key_press), 32'(exp_press));
    checkOutput("key_release", 32'(key_release), 32'(exp_release));
    for (int i = 0; i < N_KEY; i++) begin
      if (key_press[i]) begin
        n_press[i]++;
        if (first_press[i] < 0) first_press[i] = cyc;
      end
      if (key_release[i]) begin
        n_rel[i]++;
        if (first_rel[i] < 0) first_rel[i] = cyc;
      end
    end
    if (key_press == 3'b111) n_all++;
    @(negedge clk);
  endtask

  task automatic repeatStimulus(input logic [N_KEY-1:0] kn, input int n);
    for (int k = 0; k < n; k++) applyStimulus(kn);
  endtask

  task automatic pulseReset(input int cycles);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(key_state), 32'd0);
    checkOutput("rst_press", 32'(key_press), 32'd0);
    checkOutput("rst_release", 32'(key_release), 32'd0);
    modelReset();
    for (int k = 0; k < cycles; k++) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int               dur [N_KEY];
    logic [N_KEY-1:0] lvl;

    rst_n = 1'b0;
    key_n = '1;
    modelReset();
    clearStats();
    repeat (3) @(negedge clk);
    checkOutput("init_state", 32'(key_state), 32'd0);
    checkOutput("init_press", 32'(key_press), 32'd0);
    checkOutput("init_release", 32'(key_release), 32'd0);
    rst_n = 1'b1;

    // Single press on key 0
    clearStats();
    repeat (25) applyStimulus(3'b110);
    checkOutput("lat_press0", 32'(first_press[0]), 32'd19);
    checkOutput("cnt_press0", 32'(n_press[0]), 32'd1);
    checkOutput("other_press", 32'(n_press[1] + n_press[2]), 32'd0);
    checkOutput("held_state", 32'(key_state), 32'b001);

    // Key 1 bounces once before settling low
    clearStats();
    repeatStimulus(3'b100, 10);
    repeatStimulus(3'b110, 2);
    checkOutput("bounce_nopress1", 32'(n_press[1]), 32'd0);
    clearStats();
    repeatStimulus(3'b100, 25);
    checkOutput("lat_press1", 32'(first_press[1]), 32'd19);
    checkOutput("cnt_press1", 32'(n_press[1]), 32'd1);

    // Release key 0
    clearStats();
    repeatStimulus(3'b101, 25);
    checkOutput("lat_rel0", 32'(first_rel[0]), 32'd19);
    checkOutput("cnt_rel0", 32'(n_rel[0]), 32'd1);
    checkOutput("rel_state", 32'(key_state), 32'b010);

    // All keys pressed together
    repeatStimulus(3'b111, 25);
    clearStats();
    repeatStimulus(3'b000, 25);
    checkOutput("all_press_cycles", 32'(n_all), 32'd1);
    checkOutput("lat_press2_all", 32'(first_press[2]), 32'd19);

    // Reset in the middle of key 2's press debounce while key 0 is held
    repeatStimulus(3'b111, 25);
    repeatStimulus(3'b110, 25);
    repeatStimulus(3'b010, 13);
    pulseReset(3);
    clearStats();
    repeatStimulus(3'b010, 25);
    checkOutput("lat_press2_rst", 32'(first_press[2]), 32'd19);
    checkOutput("lat_press0_rst", 32'(first_press[0]), 32'd19);
    checkOutput("cnt_press2_rst", 32'(n_press[2]), 32'd1);

    // One-cycle glitches every 8 cycles must never be accepted
    clearStats();
    for (int k = 0; k < 200; k++) applyStimulus((k % 8 == 0) ? 3'b101 : 3'b010);
    checkOutput("glitch_press", 32'(n_press[0] + n_press[1] + n_press[2]), 32'd0);
    checkOutput("glitch_rel", 32'(n_rel[0] + n_rel[1] + n_rel[2]), 32'd0);
    checkOutput("glitch_state", 32'(key_state), 32'b101);

    // Random hold lengths around the debounce threshold, with rare resets
    for (int i = 0; i < N_KEY; i++) dur[i] = 0;
    lvl = key_n;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N_KEY; i++) begin
        if (dur[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          dur[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 40))
                                               : int'($urandom_range(1, 20));
        end
        dur[i]--;
      end
      if ($urandom_range(0, 999) == 0) pulseReset(2);
      applyStimulus(lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
